// File: rtl/data_mem_resp.sv
// Data-memory responder: word-organised RAM serving byte/half/word loads and stores
// as a multi-cycle slave with a programmable number of wait states.
module data_mem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [31:0] i_mem_waddr,
    input  logic [31:0] i_mem_raddr,
    input  logic [31:0] i_mem_wdata,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_ack,
    output logic        o_mem_err,
    output logic        o_hold_flag
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned AB = AW + 2;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AB-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     ram [DEPTH_WORDS];

    logic            cur_we;
    logic [AB-1:0]   cur_addr;
    logic [31:0]     cur_wdata;
    logic [2:0]      cur_f3;
    logic [AW-1:0]   cur_idx;
    logic            illegal, misal, cur_err;
    logic            enter_resp;
    logic [3:0]      wr_be;
    logic [31:0]     wr_word;
    logic [31:0]     ram_word, shifted, ld_data;

    // Address bits above the RAM span alias and are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{i_mem_waddr[31:AB], i_mem_raddr[31:AB]};

    // Access being completed: live inputs in IDLE (zero-wait path), latched copy otherwise
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_f3    = f3_q;
        if (state_q == StIdle) begin
            cur_we    = i_mem_we;
            cur_addr  = i_mem_we ? i_mem_waddr[AB-1:0] : i_mem_raddr[AB-1:0];
            cur_wdata = i_mem_wdata;
            cur_f3    = i_funct3;
        end
    end

    assign cur_idx = cur_addr[AB-1:2];

    // Error detection: funct3 legality per direction plus natural alignment
    always_comb begin
        illegal = 1'b1;
        misal   = 1'b0;
        case (cur_f3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = cur_we;
            default:                illegal = 1'b1;
        endcase
        case (cur_f3[1:0])
            2'b01:   misal = cur_addr[0];
            2'b10:   misal = |cur_addr[1:0];
            default: misal = 1'b0;
        endcase
        cur_err = illegal | misal;
    end

    // Store lane enables with the data replicated across lanes
    always_comb begin
        wr_be   = 4'b1111;
        wr_word = cur_wdata;
        case (cur_f3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << cur_addr[1:0];
                wr_word = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{cur_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_word = cur_wdata;
            end
        endcase
    end

    // Load path: right-justify the addressed lane(s) then extend
    always_comb begin
        ram_word = ram[cur_idx];
        shifted  = ram_word >> {cur_addr[1:0], 3'b000};
        case (cur_f3)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {24'b0, shifted[7:0]};
            3'b101:  ld_data = {16'b0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    // Next-state logic and registered response values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdata_d    = 32'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_mem_req) begin
                    we_d    = cur_we;
                    addr_d  = cur_addr;
                    wdata_d = cur_wdata;
                    f3_d    = cur_f3;
                    cnt_d   = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (enter_resp) begin
            ack_d   = 1'b1;
            err_d   = cur_err;
            rdata_d = (cur_we || cur_err) ? 32'b0 : ld_data;
        end
    end

    // State, latched request and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'b0;
            f3_q    <= 3'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM is not reset; error-free stores commit on the edge entering RESP
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) ram[cur_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    assign o_mem_ack   = ack_q;
    assign o_mem_err   = err_q;
    assign o_mem_rdata = rdata_q;
    // Reset gating keeps the stall low while reset is asserted
    assign o_hold_flag = rst && (((state_q == StIdle) && i_mem_req) || (state_q == StBusy));

endmodule

// File: tb/tb_data_mem_resp.sv
// Testbench for data_mem_resp: directed vector table, randomized accesses against a
// byte-array reference model, reset-mid-access and zero-wait back-to-back sequences.
module tb_data_mem_resp;

    localparam int unsigned WS = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // WAIT_STATES = 1 instance
    logic        req, we;
    logic [31:0] waddr, raddr, wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        ack, err, hold;

    // WAIT_STATES = 0 instance
    logic        req0, we0;
    logic [31:0] waddr0, raddr0, wdata0;
    logic [2:0]  f30;
    logic [31:0] rdata0;
    logic        ack0, err0, hold0;

    int checks   = 0;
    int failures = 0;

    byte unsigned mdl [4096];

    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst(rst), .i_mem_req(req), .i_mem_we(we), .i_mem_waddr(waddr),
        .i_mem_raddr(raddr), .i_mem_wdata(wdata), .i_funct3(f3), .o_mem_rdata(rdata),
        .o_mem_ack(ack), .o_mem_err(err), .o_hold_flag(hold)
    );

    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_mem_req(req0), .i_mem_we(we0), .i_mem_waddr(waddr0),
        .i_mem_raddr(raddr0), .i_mem_wdata(wdata0), .i_funct3(f30), .o_mem_rdata(rdata0),
        .o_mem_ack(ack0), .o_mem_err(err0), .o_hold_flag(hold0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory aliased to 4 KiB, rules applied arithmetically
    function automatic void model(input logic mwe, input logic [31:0] a, input logic [31:0] d,
                                  input logic [2:0] fn, output logic [31:0] erd,
                                  output logic eerr);
        int size;
        int base;
        longint unsigned v;
        bit legal;
        size  = 1 << fn[1:0];
        legal = mwe ? (fn inside {3'd0, 3'd1, 3'd2}) : (fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        base  = int'(a % 32'd4096);
        eerr  = !legal || ((base % size) != 0);
        erd   = 32'b0;
        if (eerr) return;
        if (mwe) begin
            for (int i = 0; i < size; i++) mdl[base + i] = d[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v |= longint'(mdl[base + i]) << (8 * i);
            if (!fn[2] && size < 4 && v[8*size-1]) v |= ~((64'd1 << (8 * size)) - 64'd1);
            erd = v[31:0];
        end
    endfunction

    // One access on the WAIT_STATES=1 instance, checking latency, hold and ack pulse width
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] fn, output logic [31:0] rd, output logic er);
        int lat;
        int hc;
        bit got;
        hc    = 0;
        lat   = 0;
        got   = 1'b0;
        rd    = 32'b0;
        er    = 1'b0;
        req   = 1'b1;
        we    = w;
        waddr = w ? a : $urandom;
        raddr = w ? $urandom : a;
        wdata = d;
        f3    = fn;
        #1;
        if (hold) hc++;
        @(posedge clk);
        #1;
        // Inputs after acceptance are garbage and must be ignored
        req   = 1'b0;
        we    = 1'($urandom);
        waddr = $urandom;
        raddr = $urandom;
        wdata = $urandom;
        f3    = 3'($urandom);
        while (!got && lat < 40) begin
            lat++;
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                rd  = rdata;
                er  = err;
                chk("hold_in_resp", {31'b0, hold}, 32'd0);
            end else begin
                if (hold) hc++;
                @(posedge clk);
                #1;
            end
        end
        chk("ack_latency", lat, 1 + WS);
        chk("hold_cycles", hc, 1 + WS);
        @(posedge clk);
        #1;
        chk("ack_pulse", {31'b0, ack}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, mrd;
        logic        er, merr;
        logic [5:0]  hold_pat;
        logic [6:0]  ack_pat;
        logic [31:0] a;

        vecs[0]  = '{1'b1, 32'h20,   32'h12345678, 3'b010, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h20,   32'h0,        3'b010, 32'h12345678, 1'b0};
        vecs[2]  = '{1'b1, 32'h40,   32'h0,        3'b010, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h41,   32'h123456AB, 3'b000, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 32'h42,   32'h9876CDEF, 3'b001, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'h40,   32'h0,        3'b010, 32'hCDEFAB00, 1'b0};
        vecs[6]  = '{1'b0, 32'h41,   32'h0,        3'b000, 32'hFFFFFFAB, 1'b0};
        vecs[7]  = '{1'b0, 32'h41,   32'h0,        3'b100, 32'h000000AB, 1'b0};
        vecs[8]  = '{1'b0, 32'h42,   32'h0,        3'b001, 32'hFFFFCDEF, 1'b0};
        vecs[9]  = '{1'b0, 32'h42,   32'h0,        3'b101, 32'h0000CDEF, 1'b0};
        vecs[10] = '{1'b1, 32'h22,   32'hFFFFFFFF, 3'b010, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 32'h20,   32'h0,        3'b010, 32'h12345678, 1'b0};
        vecs[12] = '{1'b0, 32'h43,   32'h0,        3'b001, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 32'h20,   32'h0,        3'b011, 32'h0,        1'b1};
        vecs[14] = '{1'b1, 32'h1004, 32'hA5A5A5A5, 3'b010, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 32'h0004, 32'h0,        3'b010, 32'hA5A5A5A5, 1'b0};
        vecs[16] = '{1'b1, 32'h20,   32'h0,        3'b100, 32'h0,        1'b1};
        vecs[17] = '{1'b0, 32'h20,   32'h0,        3'b010, 32'h12345678, 1'b0};
        vecs[18] = '{1'b0, 32'h21,   32'h0,        3'b010, 32'h0,        1'b1};
        vecs[19] = '{1'b1, 32'h23,   32'hFFFFFF77, 3'b000, 32'h0,        1'b0};
        vecs[20] = '{1'b0, 32'h20,   32'h0,        3'b010, 32'h77345678, 1'b0};

        req = 1'b1; we = 1'b0; waddr = 32'h0; raddr = 32'h0; wdata = 32'h0; f3 = 3'b010;
        req0 = 1'b1; we0 = 1'b0; waddr0 = 32'h0; raddr0 = 32'h0; wdata0 = 32'h0; f30 = 3'b010;

        // Reset: outputs quiet and hold suppressed even with a request pending
        #12;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_hold", {31'b0, hold}, 32'd0);
        chk("rst_hold0", {31'b0, hold0}, 32'd0);
        req = 1'b0;
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors
        for (int i = 0; i < 21; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er);
            model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, mrd, merr);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
        end

        // Initialise the random region so every load reads defined data
        for (int wi = 0; wi < 32; wi++) begin
            a = 32'h100 + 32'(4 * wi);
            wdata = $urandom;
            mrd = wdata;
            access(1'b1, a, mrd, 3'b010, rd, er);
            model(1'b1, a, mrd, 3'b010, mrd, merr);
            chk("init_err", {31'b0, er}, 32'd0);
        end

        // Randomized accesses with random aliasing upper address bits
        for (int n = 0; n < 300; n++) begin
            logic        rw;
            logic [2:0]  rf;
            logic [31:0] rdat;
            rw   = 1'($urandom);
            rf   = 3'($urandom);
            rdat = $urandom;
            a    = ($urandom & 32'hFFFFF000) | (32'h100 + 32'($urandom_range(0, 127)));
            access(rw, a, rdat, rf, rd, er);
            model(rw, a, rdat, rf, mrd, merr);
            chk($sformatf("rand%0d_rdata a=%08h f3=%0d we=%0d", n, a, rf, rw), rd, mrd);
            chk($sformatf("rand%0d_err", n), {31'b0, er}, {31'b0, merr});
        end

        // Reset in the middle of a store discards it
        access(1'b1, 32'h10, 32'hCAFEF00D, 3'b010, rd, er);
        req = 1'b1; we = 1'b1; waddr = 32'h10; raddr = 32'h0; wdata = 32'hDEADBEEF; f3 = 3'b010;
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("busy_hold", {31'b0, hold}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_hold", {31'b0, hold}, 32'd0);
        chk("midrst_ack", {31'b0, ack}, 32'd0);
        chk("midrst_err", {31'b0, err}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_noack", {31'b0, ack}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("postrst_noack", {31'b0, ack}, 32'd0);
        end
        @(posedge clk);
        #1;
        access(1'b0, 32'h10, 32'h0, 3'b010, rd, er);
        chk("postrst_lw", rd, 32'hCAFEF00D);
        chk("postrst_err", {31'b0, er}, 32'd0);

        // Zero-wait instance: request held high across three accesses
        @(posedge clk);
        #1;
        req0 = 1'b1; we0 = 1'b1; waddr0 = 32'h60; raddr0 = 32'h9999; wdata0 = 32'h0BADF00D;
        f30 = 3'b010;
        hold_pat = '0;
        ack_pat  = '0;
        for (int k = 0; k < 6; k++) begin
            #3;
            hold_pat[k] = hold0;
            @(posedge clk);
            #1;
            ack_pat[k+1] = ack0;
            if (k + 1 == 1) begin
                chk("b2b_store_rdata", rdata0, 32'h0);
                we0 = 1'b0; raddr0 = 32'h60; waddr0 = 32'h1234;
            end
            if (k + 1 == 3) begin
                chk("b2b_lw_rdata", rdata0, 32'h0BADF00D);
                f30 = 3'b101; raddr0 = 32'h62;
            end
            if (k + 1 == 5) begin
                chk("b2b_lhu_rdata", rdata0, 32'h00000BAD);
                chk("b2b_lhu_err", {31'b0, err0}, 32'd0);
                req0 = 1'b0;
            end
        end
        chk("b2b_hold_pattern", {26'b0, hold_pat}, 32'b010101);
        chk("b2b_ack_pattern", {25'b0, ack_pat}, 32'b0101010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
